// File: rtl/sdram_wbuf_if.sv
// sdram_wbuf_if - bus bundle for the posted-write buffer.
//
// Carries the CPU-side request/response signals and the SDRAM-controller
// request/response signals between the buffer and its neighbours.
//   slave  modport : the buffer itself (consumes CPU requests, drives the controller)
//   master modport : the environment (CPU + controller)
//
// CPU side      : cpu_address[26:0], cpu_read, cpu_write, cpu_in[7:0] -> buffer
//                 cpu_out[7:0], cpu_ready                               <- buffer
// Controller    : address[26:0], mreq, read, write, in[7:0]            <- buffer
//                 out[7:0], ce (1 = idle/ready, 0 = busy)              -> buffer
interface sdram_wbuf_if;
    logic [26:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_in;
    logic [7:0]  cpu_out;
    logic        cpu_ready;
    logic [26:0] address;
    logic        mreq;
    logic        read;
    logic        write;
    logic [7:0]  in;
    logic [7:0]  out;
    logic        ce;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_in, out, ce,
        output cpu_out, cpu_ready, address, mreq, read, write, in
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_in, out, ce,
        input  cpu_out, cpu_ready, address, mreq, read, write, in
    );
endinterface

// File: rtl/sdram_wbuf.sv
// sdram_wbuf - posted-write buffer between the CPU bus and the SDRAM controller.
//
// CPU byte writes are queued in a DEPTH-entry circular FIFO and complete in
// the same cycle unless the FIFO is full. A three-state FSM (IDLE/ACK/DONE)
// drains the FIFO to the controller one transaction at a time. A CPU read
// either forwards data from the youngest matching buffered write or waits
// for the FIFO to empty and then issues its own controller read.
//
// Ports:
//   clock - rising-edge clock for all logic
//   reset - synchronous, active-high; flushes the FIFO and idles the FSM
//   bus   - sdram_wbuf_if.slave (CPU request/response + controller request/response)
//
// Parameter:
//   DEPTH - FIFO entries, power of two in 2..16
//
// Build option:
//   WBUF_FWD_EN - when defined, builds the address comparator so read hits
//                 complete in 0 cycles; when undefined every read waits for
//                 the drain and goes to the controller (strict program order).
module sdram_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    sdram_wbuf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [26:0]   r_addr [DEPTH];
    logic [7:0]    r_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic          r_mreq;
    logic          r_read;
    logic          r_write;
    logic          r_rd_done;
    logic [26:0]   r_address;
    logic [7:0]    r_in;
    logic [7:0]    r_cpu_out;

    state_t        w_state_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_pop;
    logic          w_rd_cap;
    logic          w_hit;
    logic [7:0]    w_hit_data;
    logic          w_miss;
    logic          w_cpu_ready;
    logic          w_mreq_nxt;
    logic          w_read_nxt;
    logic          w_write_nxt;
    logic [26:0]   w_address_nxt;
    logic [7:0]    w_in_nxt;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == {(AW+1){1'b0}});
    // A write while full is refused outright, even if the head pops this cycle.
    assign w_enq   = bus.cpu_write && !w_full;

`ifdef WBUF_FWD_EN
    // Forwarding search: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < r_count) &&
                (r_addr[r_rd_ptr + AW'(i)] == bus.cpu_address)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[r_rd_ptr + AW'(i)];
            end else begin
                w_hit      = w_hit;
                w_hit_data = w_hit_data;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 8'h00;
`endif

    // A miss stays pending until its rd_done pulse; masking with rd_done stops a
    // second read being issued on the very cycle the first one is delivered.
    assign w_miss = bus.cpu_read && !w_hit && !r_rd_done;

    // CPU handshake: writes gated by full, reads by hit or miss completion.
    always_comb begin
        if (bus.cpu_write) begin
            w_cpu_ready = !w_full;
        end else if (bus.cpu_read) begin
            w_cpu_ready = w_hit || r_rd_done;
        end else begin
            w_cpu_ready = 1'b1;
        end
    end

    assign bus.cpu_ready = w_cpu_ready;
    assign bus.cpu_out   = w_hit ? w_hit_data : r_cpu_out;
    assign bus.address   = r_address;
    assign bus.mreq      = r_mreq;
    assign bus.read      = r_read;
    assign bus.write     = r_write;
    assign bus.in        = r_in;

    // Drain/issue FSM next-state and next controller request fields.
    always_comb begin
        w_state_nxt   = r_state;
        w_mreq_nxt    = r_mreq;
        w_read_nxt    = r_read;
        w_write_nxt   = r_write;
        w_address_nxt = r_address;
        w_in_nxt      = r_in;
        w_pop         = 1'b0;
        w_rd_cap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Drain first; a miss only goes out once the FIFO is empty.
                if (bus.ce && !r_mreq && !w_empty) begin
                    w_mreq_nxt    = 1'b1;
                    w_write_nxt   = 1'b1;
                    w_read_nxt    = 1'b0;
                    w_address_nxt = r_addr[r_rd_ptr];
                    w_in_nxt      = r_data[r_rd_ptr];
                    w_state_nxt   = ST_ACK;
                end else if (bus.ce && !r_mreq && w_empty && w_miss) begin
                    w_mreq_nxt    = 1'b1;
                    w_read_nxt    = 1'b1;
                    w_write_nxt   = 1'b0;
                    w_address_nxt = bus.cpu_address;
                    w_state_nxt   = ST_ACK;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_ACK: begin
                // ce falling means the controller has taken the request.
                if (!bus.ce) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_DONE: begin
                // ce rising means the operation finished; request fields drop here.
                if (bus.ce) begin
                    w_mreq_nxt  = 1'b0;
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    w_pop       = r_write;
                    w_rd_cap    = r_read;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_mreq_nxt  = 1'b0;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, controller request registers and CPU read-return registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mreq    <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= 27'h0000000;
            r_in      <= 8'h00;
            r_cpu_out <= 8'h00;
            r_rd_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mreq    <= w_mreq_nxt;
            r_read    <= w_read_nxt;
            r_write   <= w_write_nxt;
            r_address <= w_address_nxt;
            r_in      <= w_in_nxt;
            // Only signal completion if the CPU is still asking for this address;
            // an abandoned miss is discarded without a ready pulse.
            r_rd_done <= w_rd_cap && bus.cpu_read && (bus.cpu_address == r_address);
            if (w_rd_cap) begin
                r_cpu_out <= bus.out;
            end else if (bus.cpu_read && w_hit) begin
                r_cpu_out <= w_hit_data;
            end else begin
                r_cpu_out <= r_cpu_out;
            end
        end
    end

    // FIFO pointers and occupancy; enqueue and pop together leave count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care outside the valid window.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= bus.cpu_address;
            r_data[r_wr_ptr] <= bus.cpu_in;
        end
    end
endmodule

// File: doc/sdram_wbuf.md
# sdram_wbuf

Posted-write buffer between the CPU bus and the SDRAM controller. CPU byte writes go into a small FIFO and complete in one cycle. The FIFO drains to the controller in the background, one transaction at a time. CPU reads either forward data from the youngest matching buffered write or wait for the FIFO to drain and then issue a controller read. This keeps store-heavy code from stalling on every SDRAM row cycle.

## Interface

Parameters:
- DEPTH, 4: FIFO entries (power of two, 2..16); each entry holds {addr[26:0], data[7:0]}.

Ports:
- clock  in  1  CPU-domain clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- cpu_address  in  27  CPU byte address.
- cpu_read  in  1  read request (level, held until cpu_ready).
- cpu_write  in  1  write request (level, held until cpu_ready); never together with cpu_read.
- cpu_in  in  8  write data.
- cpu_out  out  8  read data, valid when cpu_ready=1 and cpu_read=1.
- cpu_ready  out  1  current CPU request completes this cycle.
- address  out  27  to controller.
- mreq  out  1  to controller, registered.
- read  out  1  to controller, registered.
- write  out  1  to controller, registered.
- in  out  8  to controller, write data.
- out  in  8  from controller, read data.
- ce  in  1  from controller; 1 = idle/ready, 0 = busy.

## Operation

- FIFO: circular, wr_ptr/rd_ptr of log2(DEPTH) bits with wrap, plus count of log2(DEPTH)+1 bits. full = count==DEPTH; empty = count==0.
- CPU write: cpu_ready = !full (combinational). On cpu_write && !full, the entry is enqueued at the edge. A write while full stalls; no enqueue happens even if a pop occurs in the same cycle.
- CPU read hit (forwarding): cpu_address is compared against all valid entries. The youngest match wins. cpu_ready=1 and cpu_out = that entry's data in the same cycle.
- CPU read miss: cpu_ready=0 until the FIFO is empty and the miss read to the controller completes.
- No request: cpu_ready=1; cpu_out holds its last value.
- Drain/issue FSM states: IDLE, ACK, DONE.
  - IDLE: when ce=1, mreq=0 and !empty, drive address/in from the head entry, set mreq=1 and write=1, then go to ACK. Otherwise, when ce=1, empty and a read miss is pending, set mreq=1, read=1 and address=cpu_address, then go to ACK. Drain has priority over the miss.
  - ACK: wait for ce=0 (controller accepted), then go to DONE.
  - DONE: wait for ce=1. On that edge, clear mreq/read/write and return to IDLE. For a write, pop the head (rd_ptr+1, count-1). For a read, cpu_out<=out and rd_done<=1 for exactly one cycle.
- cpu_ready for a miss = rd_done. rd_done clears the next cycle.
- If the CPU drops cpu_read during a miss, the read still completes and the data is discarded.
- Simultaneous enqueue and pop in the same cycle (not full): count unchanged, both pointers advance.
- Reset mid-operation: FIFO flushed (count=0, pointers 0), FSM to IDLE, mreq/read/write=0. The first issue after reset still requires ce=1, so an in-flight controller operation finishes unobserved.

## Timing

- Reset values: mreq=0, read=0, write=0, address=0, in=0, cpu_out=0, rd_done=0, cpu_ready=1 (no request).
- Write latency to CPU: 0 cycles when not full.
- Forwarded read: 0 cycles (combinational).
- Miss read: drain time + 1 issue cycle + controller busy time + 1 cycle (rd_done).
- mreq always has at least one low cycle between consecutive transactions. This lets the controller clear its done flag.
- Controller request fields stay stable from issue until the DONE-completion edge.

## Configuration

- WBUF_FWD_EN defined: the address comparator is built and read hits complete in 0 cycles.
- WBUF_FWD_EN undefined: no comparator. Every read waits for the FIFO to drain and goes to the controller, giving strict program-order memory.

## Test plan

- Reset: hold reset 3 cycles with cpu_write=1 → mreq=0, cpu_ready=1 with no request, count=0, nothing enqueued.
- Posted writes: 4 writes to 0x100..0x103 with data 0xA0..0xA3 on consecutive cycles, controller model busy 7 cycles each → all 4 get cpu_ready=1 immediately. The controller sees 4 writes in order with correct address/data. A 5th write stalls until the first pop.
- Forwarding (WBUF_FWD_EN): write 0x55 then 0x66 to 0x200, then read 0x200 while both are buffered → cpu_ready=1 the same cycle, cpu_out=0x66.
- Miss read: FIFO holding 2 entries, read 0x300 with the model returning 0x3C → the read is issued only after both writes complete, then cpu_ready=1 for one cycle with cpu_out=0x3C.
- No forwarding (WBUF_FWD_EN undefined): write 0x77 to 0x400, then read 0x400 → drain completes first, then a controller read is issued and returns the model's value.
- Reset during ACK of a write with count=3 → count=0, mreq=0 next cycle. No new issue happens until ce=1, then the FSM stays idle.
